// File: rtl/accumulator_pkg.sv
// Shared definitions for the channel accumulator: default widths, the
// channel-index width helper and the saturation limit helpers.
package accumulator_pkg;

    localparam int DEFAULT_IN_WIDTH  = 14;
    localparam int DEFAULT_OUT_WIDTH = 15;
    localparam int DEFAULT_CHANNELS  = 4;

    // Width of a channel index; never less than one bit
    function automatic int ch_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    // Largest positive two's-complement value of the given width (low bits meaningful)
    function automatic logic [63:0] sat_max(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement value of the given width (low bits meaningful)
    function automatic logic [63:0] sat_min(input int width);
        return ~sat_max(width);
    endfunction

endpackage

// File: rtl/accumulator_add_sat.sv
// Combinational extend-add with overflow detection for one accumulator update.
// Optional clamping is enabled by defining ACCUM_SATURATE_EN; otherwise the
// result wraps to OUT_WIDTH bits.
module accumulator_add_sat
    import accumulator_pkg::*;
#(
    parameter int IN_WIDTH  = DEFAULT_IN_WIDTH,
    parameter int OUT_WIDTH = DEFAULT_OUT_WIDTH
) (
    input  logic signed [OUT_WIDTH-1:0] base,
    input  logic signed [IN_WIDTH-1:0]  a,
    output logic signed [OUT_WIDTH-1:0] sum,
    output logic                        ovf
);

    logic signed [OUT_WIDTH:0] wide;

    // One guard bit is enough: the true sum of two in-range operands always fits
    assign wide = {base[OUT_WIDTH-1], base} + {{(OUT_WIDTH + 1 - IN_WIDTH){a[IN_WIDTH-1]}}, a};
    assign ovf  = wide[OUT_WIDTH] ^ wide[OUT_WIDTH-1];

`ifdef ACCUM_SATURATE_EN
    localparam logic signed [OUT_WIDTH-1:0] SAT_MAX = OUT_WIDTH'(sat_max(OUT_WIDTH));
    localparam logic signed [OUT_WIDTH-1:0] SAT_MIN = OUT_WIDTH'(sat_min(OUT_WIDTH));

    // Clamp toward the sign of the true (guard-bit) result when it does not fit
    always_comb begin
        sum = wide[OUT_WIDTH-1:0];
        if (ovf) begin
            sum = wide[OUT_WIDTH] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign sum = wide[OUT_WIDTH-1:0];
`endif

endmodule

// File: rtl/channel_accumulator.sv
// Multi-channel signed accumulator with sticky per-channel overflow flags and
// a one-cycle registered result port. Define ACCUM_SATURATE_EN to clamp
// overflowing results instead of wrapping them.
module channel_accumulator
    import accumulator_pkg::*;
#(
    parameter int IN_WIDTH  = DEFAULT_IN_WIDTH,
    parameter int OUT_WIDTH = DEFAULT_OUT_WIDTH,
    parameter int CHANNELS  = DEFAULT_CHANNELS
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 clear,
    input  logic                                 in_valid,
    input  logic [ch_width(CHANNELS)-1:0]        ch,
    input  logic                                 load,
    input  logic signed [OUT_WIDTH-1:0]          init,
    input  logic signed [IN_WIDTH-1:0]           a,
    output logic                                 out_valid,
    output logic [ch_width(CHANNELS)-1:0]        out_ch,
    output logic signed [OUT_WIDTH-1:0]          y,
    output logic                                 overflow
);

    localparam int CW = ch_width(CHANNELS);

    logic signed [OUT_WIDTH-1:0] acc [CHANNELS];
    logic [CHANNELS-1:0]         ovf;

    logic                        in_range;
    logic                        accept;
    logic [CW-1:0]               ch_idx;
    logic signed [OUT_WIDTH-1:0] base;
    logic signed [OUT_WIDTH-1:0] sum;
    logic                        add_ovf;
    logic                        new_ovf;

    // Out-of-range indices are dropped; the safe index keeps array reads in bounds
    assign in_range = (32'(ch) < CHANNELS);
    assign accept   = in_valid & in_range;
    assign ch_idx   = in_range ? ch : '0;

    // Reading the registered array directly means back-to-back hits see the fresh value
    assign base    = load ? init : acc[ch_idx];
    assign new_ovf = (load ? 1'b0 : ovf[ch_idx]) | add_ovf;

    accumulator_add_sat #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_add (
        .base (base),
        .a    (a),
        .sum  (sum),
        .ovf  (add_ovf)
    );

    // Channel storage and result register; clear outranks an accepted sample
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i] <= '0;
            end
            ovf       <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            y         <= '0;
            overflow  <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i] <= '0;
            end
            ovf       <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            acc[ch_idx] <= sum;
            ovf[ch_idx] <= new_ovf;
            out_valid   <= 1'b1;
            out_ch      <= ch;
            y           <= sum;
            overflow    <= new_ovf;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_channel_accumulator.sv
// Testbench for channel_accumulator: directed scenarios plus randomized traffic
// checked against an arithmetic model. Honours ACCUM_SATURATE_EN in the model.
module tb_channel_accumulator;

    localparam int  OW   = 15;
    localparam int  NCH  = 4;
    localparam longint MAXV = (64'sd1 <<< (OW - 1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (OW - 1));

    logic               clk;
    logic               reset_n;
    logic               clear;
    logic               in_valid;
    logic [1:0]         ch;
    logic               load;
    logic signed [14:0] init;
    logic signed [13:0] a;
    logic               out_valid;
    logic [1:0]         out_ch;
    logic signed [14:0] y;
    logic               overflow;

    // Second instance with a non-power-of-two channel count for out-of-range indices
    logic               in_valid_b;
    logic [2:0]         ch_b;
    logic signed [13:0] a_b;
    logic               out_valid_b;
    logic [2:0]         out_ch_b;
    logic signed [14:0] y_b;
    logic               overflow_b;

    int checks = 0;
    int errors = 0;

    longint model_acc [NCH];
    bit     model_ovf [NCH];
    bit     exp_valid;
    int     exp_ch;
    longint exp_y;
    bit     exp_ovf;

    channel_accumulator dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .ch        (ch),
        .load      (load),
        .init      (init),
        .a         (a),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .y         (y),
        .overflow  (overflow)
    );

    channel_accumulator #(.CHANNELS(5)) dut_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (1'b0),
        .in_valid  (in_valid_b),
        .ch        (ch_b),
        .load      (1'b0),
        .init      (15'sd0),
        .a         (a_b),
        .out_valid (out_valid_b),
        .out_ch    (out_ch_b),
        .y         (y_b),
        .overflow  (overflow_b)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic longint wrapOut(input longint s);
        longint m;
        m = ((s % (64'sd1 <<< OW)) + (64'sd1 <<< OW)) % (64'sd1 <<< OW);
        return (m > MAXV) ? m - (64'sd1 <<< OW) : m;
    endfunction

    task automatic checkOutput(input string tag, input logic signed [31:0] got,
                               input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d required %0d", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NCH; i++) begin
            model_acc[i] = 0;
            model_ovf[i] = 1'b0;
        end
        exp_valid = 1'b0;
        exp_ch    = 0;
        exp_y     = 0;
        exp_ovf   = 1'b0;
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'(exp_valid));
        checkOutput({tag, "_ch"}, 32'(out_ch), exp_ch);
        checkOutput({tag, "_y"}, 32'(y), 32'(exp_y));
        checkOutput({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    endtask

    task automatic applyStimulus(input bit iv, input bit ld, input int c, input longint ini,
                                 input longint av, input bit clr, input string tag);
        longint s;
        longint r;
        bit     o;
        in_valid = iv;
        load     = ld;
        ch       = 2'(c);
        init     = 15'(ini);
        a        = 14'(av);
        clear    = clr;
        if (clr) begin
            for (int i = 0; i < NCH; i++) begin
                model_acc[i] = 0;
                model_ovf[i] = 1'b0;
            end
            exp_valid = 1'b0;
        end else if (iv) begin
            s = (ld ? ini : model_acc[c]) + av;
            o = (s > MAXV) || (s < MINV);
`ifdef ACCUM_SATURATE_EN
            r = (s > MAXV) ? MAXV : ((s < MINV) ? MINV : s);
`else
            r = wrapOut(s);
`endif
            model_acc[c] = r;
            model_ovf[c] = (ld ? 1'b0 : model_ovf[c]) | o;
            exp_valid = 1'b1;
            exp_ch    = c;
            exp_y     = r;
            exp_ovf   = model_ovf[c];
        end else begin
            exp_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        load     = 1'b0;
        clear    = 1'b0;
        checkAll(tag);
    endtask

    initial begin
        reset_n    = 1'b0;
        clear      = 1'b0;
        in_valid   = 1'b0;
        ch         = '0;
        load       = 1'b0;
        init       = '0;
        a          = '0;
        in_valid_b = 1'b0;
        ch_b       = '0;
        a_b        = '0;
        modelReset();

        repeat (2) @(posedge clk);
        #1;
        checkAll("reset");
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic accumulation on channel 0
        applyStimulus(1, 1, 0, 0, 12, 0, "acc0");
        checkOutput("acc0_lit", 32'(y), 12);
        applyStimulus(1, 0, 0, 0, -7, 0, "acc1");
        checkOutput("acc1_lit", 32'(y), 5);
        applyStimulus(1, 0, 0, 0, 2, 0, "acc2");
        checkOutput("acc2_lit", 32'(y), 7);
        applyStimulus(1, 0, 0, 0, 3, 0, "acc3");
        checkOutput("acc3_lit", 32'(y), 10);
        checkOutput("acc3_ovf_lit", 32'(overflow), 0);

        // Overflow on channel 1, sticky flag, then load clears it
        applyStimulus(1, 1, 1, 16380, 0, 0, "ovf0");
        applyStimulus(1, 0, 1, 0, 8190, 0, "ovf1");
`ifdef ACCUM_SATURATE_EN
        checkOutput("ovf1_lit", 32'(y), 16383);
`else
        checkOutput("ovf1_lit", 32'(y), -8198);
`endif
        checkOutput("ovf1_flag_lit", 32'(overflow), 1);
        applyStimulus(1, 0, 1, 0, -1, 0, "ovf2");
`ifdef ACCUM_SATURATE_EN
        checkOutput("ovf2_lit", 32'(y), 16382);
`endif
        checkOutput("ovf2_flag_lit", 32'(overflow), 1);
        applyStimulus(1, 1, 1, 0, -123, 0, "ovf3");
        checkOutput("ovf3_lit", 32'(y), -123);
        checkOutput("ovf3_flag_lit", 32'(overflow), 0);

        // Clear with a coincident sample drops the sample and zeroes everything
        applyStimulus(1, 0, 0, 0, 9, 1, "clr");
        checkOutput("clr_valid_lit", 32'(out_valid), 0);
        for (int i = 0; i < NCH; i++) begin
            applyStimulus(1, 0, i, 0, 0, 0, "clr_probe");
            checkOutput("clr_probe_lit", 32'(y), 0);
        end
        applyStimulus(1, 0, 0, 0, 1, 0, "clr_after");
        checkOutput("clr_after_lit", 32'(y), 1);

        // Interleaved channels with back-to-back hits on channel 2
        applyStimulus(0, 0, 0, 0, 0, 1, "il_clr");
        applyStimulus(1, 0, 0, 0, 5, 0, "il0");
        applyStimulus(1, 0, 2, 0, -3, 0, "il1");
        applyStimulus(1, 0, 2, 0, -3, 0, "il2");
        checkOutput("il2_lit", 32'(y), -6);
        applyStimulus(0, 0, 0, 0, 0, 0, "il3");
        applyStimulus(1, 0, 0, 0, 0, 0, "il_p0");
        checkOutput("il_p0_lit", 32'(y), 5);
        applyStimulus(1, 0, 1, 0, 0, 0, "il_p1");
        checkOutput("il_p1_lit", 32'(y), 0);
        applyStimulus(1, 0, 3, 0, 0, 0, "il_p3");
        checkOutput("il_p3_lit", 32'(y), 0);
        applyStimulus(1, 0, 3, 0, 77, 0, "pre_rst");

        // Asynchronous reset between edges with a sample in flight
        in_valid = 1'b1;
        ch       = 2'd0;
        a        = 14'sd100;
        #3 reset_n = 1'b0;
        #1;
        modelReset();
        checkAll("rst_async");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkAll("rst_held");
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        checkAll("rst_idle");
        applyStimulus(1, 0, 0, 0, 4, 0, "rst_first");
        checkOutput("rst_first_lit", 32'(y), 4);

        // Out-of-range channel index on the five-channel instance
        in_valid_b = 1'b1;
        ch_b       = 3'd4;
        a_b        = 14'sd7;
        @(posedge clk);
        #1;
        checkOutput("oor_in_valid", 32'(out_valid_b), 1);
        checkOutput("oor_in_y", 32'(y_b), 7);
        ch_b = 3'd5;
        a_b  = 14'sd3;
        @(posedge clk);
        #1;
        checkOutput("oor5_valid", 32'(out_valid_b), 0);
        checkOutput("oor5_y_hold", 32'(y_b), 7);
        checkOutput("oor5_ch_hold", 32'(out_ch_b), 4);
        ch_b = 3'd7;
        @(posedge clk);
        #1;
        checkOutput("oor7_valid", 32'(out_valid_b), 0);
        ch_b = 3'd4;
        a_b  = 14'sd1;
        @(posedge clk);
        #1;
        in_valid_b = 1'b0;
        checkOutput("oor_after_y", 32'(y_b), 8);
        checkOutput("oor_after_ovf", 32'(overflow_b), 0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 3) != 0,
                          $urandom_range(0, 7) == 0,
                          int'($urandom_range(0, NCH - 1)),
                          longint'($urandom_range(0, 32767)) - 16384,
                          longint'($urandom_range(0, 16383)) - 8192,
                          $urandom_range(0, 39) == 0,
                          "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
